// File: rtl/audio_codec_pkg.sv
// Shared constants and slot mapping for the I2S codec master.
// Frame layout: 64 bit slots, 32 per channel, slot 0 is the I2S delay bit.
package audio_codec_pkg;

  localparam int SLOTS_PER_FRAME   = 64;
  localparam int SLOTS_PER_CHANNEL = 32;
  localparam int SLOT_W            = $clog2(SLOTS_PER_FRAME);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // Slots 1..width carry sample bits MSB first; every other slot is 0.
  function automatic logic slot_bit(input logic [31:0] sample,
                                    input logic [4:0]  slot,
                                    input int          width);
    logic [4:0] idx;
    slot_bit = 1'b0;
    if (slot != 5'd0 && int'(slot) <= width) begin
      idx      = 5'(width - int'(slot));
      slot_bit = sample[idx];
    end
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit clock and frame timing: divides clk_clk into BCLK, counts 64 slots
// per frame and emits single-cycle rise/fall/frame-start strobes.
module i2s_clk_gen
  import audio_codec_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  output logic              bclk,
  output logic              lrck,
  output logic [SLOT_W-1:0] bit_cnt,
  output logic              rise,
  output logic              fall,
  output logic              frame_start
);

  localparam int              HC_W    = $clog2(BCLK_HALF);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(BCLK_HALF - 1);

  logic [HC_W-1:0] hc;
  logic            tick;

  assign tick        = (hc == HC_LAST);
  assign rise        = tick & ~bclk;
  assign fall        = tick & bclk;
  assign frame_start = fall & (bit_cnt == SLOT_W'(SLOTS_PER_FRAME - 1));
  assign lrck        = bit_cnt[SLOT_W-1];

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hc      <= '0;
      bclk    <= 1'b0;
      bit_cnt <= SLOT_W'(SLOTS_PER_FRAME - 1);
    end else begin
      hc <= tick ? '0 : hc + 1'b1;
      if (tick) bclk <= ~bclk;
      if (fall) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_codec_master.sv
// I2S master towards an audio codec core: serialises tx pairs onto adcdat
// through a one-deep holding register and deserialises dacdat into rx pairs.
module i2s_codec_master
  import audio_codec_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_HALF    = 8
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [SAMPLE_WIDTH-1:0] tx_left,
  input  logic [SAMPLE_WIDTH-1:0] tx_right,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_underrun,
  output logic [SAMPLE_WIDTH-1:0] rx_left,
  output logic [SAMPLE_WIDTH-1:0] rx_right,
  output logic                    rx_valid,
  output logic                    bclk,
  output logic                    adclrck,
  output logic                    daclrck,
  output logic                    adcdat,
  input  logic                    dacdat
);

  localparam logic [4:0]        LAST_SLOT = 5'(SAMPLE_WIDTH);
  localparam logic [SLOT_W-1:0] RX_LAST   = SLOT_W'(SLOTS_PER_CHANNEL + SAMPLE_WIDTH);

  logic              rise, fall, frame_start, lrck;
  logic [SLOT_W-1:0] bit_cnt, bit_cnt_next;

  i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bclk          (bclk),
    .lrck          (lrck),
    .bit_cnt       (bit_cnt),
    .rise          (rise),
    .fall          (fall),
    .frame_start   (frame_start)
  );

  assign adclrck      = lrck;
  assign daclrck      = lrck;
  assign bit_cnt_next = bit_cnt + 1'b1;

  // ---------------- transmit path ----------------
  logic                    hold_full, accept;
  logic [SAMPLE_WIDTH-1:0] hold_left, hold_right, frame_left, frame_right;
  channel_e                tx_ch;
  logic [31:0]             tx_sample;

  assign tx_ready = reset_reset_n & ~hold_full;
  assign accept   = tx_valid & tx_ready;

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    tx_ch     = channel_e'(bit_cnt_next[SLOT_W-1]);
    tx_sample = '0;
    if (tx_ch == CH_LEFT) tx_sample = 32'(frame_left);
    else                  tx_sample = 32'(frame_right);
  end

  // NOTE: holding data needs no reset; it is only ever read while hold_full.
  always_ff @(posedge clk_clk) begin
    if (accept) begin
      hold_left  <= tx_left;
      hold_right <= tx_right;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hold_full   <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
      adcdat      <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= frame_start & ~hold_full;
      if (frame_start) begin
        frame_left  <= hold_full ? hold_left  : '0;
        frame_right <= hold_full ? hold_right : '0;
      end
      // The slot-0 delay bit maps to 0, so the frame-start load never leaks.
      if (fall) adcdat <= slot_bit(tx_sample, bit_cnt_next[4:0], SAMPLE_WIDTH);
      if (frame_start && hold_full) hold_full <= 1'b0;
      else if (accept)              hold_full <= 1'b1;
    end
  end

  // ---------------- receive path ----------------
  logic                    rx_slot_active, rx_done;
  logic [SAMPLE_WIDTH-1:0] rx_sh_left, rx_sh_right;

  assign rx_slot_active = (bit_cnt[4:0] != 5'd0) && (bit_cnt[4:0] <= LAST_SLOT);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rx_sh_left  <= '0;
      rx_sh_right <= '0;
      rx_done     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_left     <= '0;
      rx_right    <= '0;
    end else begin
      rx_done  <= rise & (bit_cnt == RX_LAST);
      rx_valid <= rx_done;
      if (rx_done) begin
        rx_left  <= rx_sh_left;
        rx_right <= rx_sh_right;
      end
      if (rise && rx_slot_active) begin
        if (channel_e'(bit_cnt[SLOT_W-1]) == CH_LEFT)
          rx_sh_left  <= {rx_sh_left[SAMPLE_WIDTH-2:0], dacdat};
        else
          rx_sh_right <= {rx_sh_right[SAMPLE_WIDTH-2:0], dacdat};
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_master.sv
// Self-checking bench for i2s_codec_master: a frame-arithmetic reference
// model compared every cycle, plus hand-computed timing and data pins.
module tb_i2s_codec_master;

  localparam int SW        = 16;
  localparam int BH        = 2;
  localparam int SLOT_CYC  = 2 * BH;
  localparam int FRAME_CYC = 128 * BH;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic [SW-1:0] tx_left = '0, tx_right = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_underrun, rx_valid;
  logic [SW-1:0] rx_left, rx_right;
  logic          bclk, adclrck, daclrck, adcdat, dacdat;
  logic          loopback = 1'b0, rand_dac = 1'b0;

  assign dacdat = loopback ? adcdat : rand_dac;

  i2s_codec_master #(.SAMPLE_WIDTH(SW), .BCLK_HALF(BH)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .tx_left       (tx_left),
    .tx_right      (tx_right),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_underrun   (tx_underrun),
    .rx_left       (rx_left),
    .rx_right      (rx_right),
    .rx_valid      (rx_valid),
    .bclk          (bclk),
    .adclrck       (adclrck),
    .daclrck       (daclrck),
    .adcdat        (adcdat),
    .dacdat        (dacdat)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t = clk edges since reset release; all timing is derived from it.
  bit            m_live = 1'b0;
  int            m_t = 0;
  bit            m_hold_full, m_underrun, m_rx_pend, m_rx_valid, m_acc, m_fs;
  logic [SW-1:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
  logic [SW-1:0] m_asm_l, m_asm_r, m_rx_l, m_rx_r;
  int            m_bc, m_s;

  function automatic int slot_of(input int t);
    return (63 + t / SLOT_CYC) % 64;
  endfunction

  function automatic logic exp_adc(input int t);
    int bc, s;
    logic [SW-1:0] smp;
    bc = slot_of(t);
    s  = bc % 32;
    if (s < 1 || s > SW) return 1'b0;
    smp = (bc < 32) ? m_cur_l : m_cur_r;
    return smp[SW-s];
  endfunction

  always begin
    @(posedge clk_clk);
    if (!reset_reset_n) begin
      m_live = 1'b1; m_t = 0; m_hold_full = 1'b0; m_underrun = 1'b0;
      m_rx_pend = 1'b0; m_rx_valid = 1'b0;
      m_cur_l = '0; m_cur_r = '0; m_asm_l = '0; m_asm_r = '0; m_rx_l = '0; m_rx_r = '0;
    end else if (m_live) begin
      m_t++;
      m_acc      = tx_valid && !m_hold_full;
      m_fs       = (m_t % FRAME_CYC) == SLOT_CYC;
      m_underrun = m_fs && !m_hold_full;
      m_rx_valid = m_rx_pend;
      if (m_rx_pend) begin
        m_rx_l = m_asm_l; m_rx_r = m_asm_r; m_rx_pend = 1'b0;
      end
      if (m_fs) begin
        if (m_hold_full) begin
          m_cur_l = m_hold_l; m_cur_r = m_hold_r; m_hold_full = 1'b0;
        end else begin
          m_cur_l = '0; m_cur_r = '0;
        end
      end
      if (m_acc) begin
        m_hold_l = tx_left; m_hold_r = tx_right; m_hold_full = 1'b1;
      end
      if (m_t % SLOT_CYC == BH) begin
        m_bc = slot_of(m_t);
        m_s  = m_bc % 32;
        if (m_s >= 1 && m_s <= SW) begin
          if (m_bc < 32) m_asm_l[SW-m_s] = dacdat;
          else           m_asm_r[SW-m_s] = dacdat;
        end
        if (m_bc == 32 + SW) m_rx_pend = 1'b1;
      end
    end
    #1;
    if (m_live) begin
      check("bclk",        bclk,        64'((m_t / BH) % 2));
      check("adclrck",     adclrck,     64'(slot_of(m_t) / 32));
      check("daclrck",     daclrck,     64'(slot_of(m_t) / 32));
      check("adcdat",      adcdat,      exp_adc(m_t));
      check("tx_ready",    tx_ready,    reset_reset_n && !m_hold_full);
      check("tx_underrun", tx_underrun, m_underrun);
      check("rx_valid",    rx_valid,    m_rx_valid);
      check("rx_left",     rx_left,     m_rx_l);
      check("rx_right",    rx_right,    m_rx_r);
    end
  end

  // ---------------- rx collector for loopback ----------------
  bit          lb_phase = 1'b0;
  logic [31:0] rxq[$];

  always begin
    @(posedge clk_clk);
    #3;
    if (lb_phase && rx_valid) rxq.push_back({rx_left, rx_right});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [63:0] cap;
  int          under_cnt, ones_cnt, acc_cnt, k, n;
  bit          pending, found;

  initial begin
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    tx_left = 16'hA5C3; tx_right = 16'h0001; tx_valid = 1'b1;

    // Release timing at BCLK_HALF=2.
    @(posedge clk_clk); #2;
    check("e1_bclk", bclk, 0);
    check("e1_ready_after_accept", tx_ready, 0);
    @(negedge clk_clk); tx_valid = 1'b0;
    @(posedge clk_clk); #2;
    check("e2_bclk_rise", bclk, 1);
    @(posedge clk_clk); #2;
    check("e3_adclrck", adclrck, 1);
    @(posedge clk_clk); #2;
    check("e4_bclk_fall", bclk, 0);
    check("e4_adclrck", adclrck, 0);
    check("e4_no_underrun", tx_underrun, 0);

    // Capture adcdat at each rise of the first frame.
    cap = '0;
    for (int s = 0; s < 64; s++) begin
      repeat (BH) @(posedge clk_clk);
      #2; cap[s] = adcdat;
      repeat (BH) @(posedge clk_clk);
    end
    check("frame_left_slots",  cap[31:0],  64'h0001874A);
    check("frame_right_slots", cap[63:32], 64'h00010000);

    // Two frames with no tx_valid: one underrun each, silent data.
    under_cnt = 0; ones_cnt = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(posedge clk_clk); #2;
      if (tx_underrun) under_cnt++;
      if (adcdat)      ones_cnt++;
    end
    check("underrun_pulses", under_cnt, 2);
    check("silent_adcdat",   ones_cnt,  0);

    // Loopback with tx_valid held high.
    acc_cnt = 0; k = 0; pending = 1'b0;
    for (int i = 0; i < 6 * FRAME_CYC; i++) begin
      @(negedge clk_clk);
      if (pending) begin
        acc_cnt++; k++;
        if (k == 1) begin tx_left = 16'h7FFF; tx_right = 16'h8000; end
        else begin tx_left = SW'($urandom); tx_right = SW'($urandom); end
      end
      if (i == 0) begin
        loopback = 1'b1; lb_phase = 1'b1; tx_valid = 1'b1;
        tx_left = 16'h8000; tx_right = 16'h7FFF;
      end
      pending = tx_valid && tx_ready;
    end
    lb_phase = 1'b0;
    check("accepts_per_frame", acc_cnt, 6);
    check("rx_pairs_count", rxq.size(), 6);
    check("rx_pair0", (rxq.size() > 0) ? rxq[0] : 32'hFFFFFFFF, 32'h00000000);
    check("rx_pair1", (rxq.size() > 1) ? rxq[1] : 32'hFFFFFFFF, 32'h80007FFF);
    check("rx_pair2", (rxq.size() > 2) ? rxq[2] : 32'hFFFFFFFF, 32'h7FFF8000);

    // Random traffic with random dacdat.
    loopback = 1'b0;
    for (int i = 0; i < 4 * FRAME_CYC; i++) begin
      @(negedge clk_clk);
      tx_valid = 1'($urandom_range(0, 1));
      tx_left  = SW'($urandom);
      tx_right = SW'($urandom);
      rand_dac = 1'($urandom);
    end

    // Abort a frame at bit_cnt = 40.
    found = 1'b0;
    for (int i = 0; i < FRAME_CYC && !found; i++) begin
      @(negedge clk_clk);
      rand_dac = 1'($urandom);
      if (m_t % FRAME_CYC == 165) found = 1'b1;
    end
    check("reset_point_found", found, 1);
    reset_reset_n = 1'b0; tx_valid = 1'b0;
    @(posedge clk_clk); #2;
    check("rst_bclk",     bclk,     0);
    check("rst_adclrck",  adclrck,  1);
    check("rst_adcdat",   adcdat,   0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_left",  rx_left,  0);
    @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1; loopback = 1'b1;
    n = 0;
    for (int i = 1; i <= 1000 && n == 0; i++) begin
      @(posedge clk_clk); #2;
      if (rx_valid) n = i;
    end
    check("rx_latency_after_reset", n, 199);

    repeat (FRAME_CYC) @(posedge clk_clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
